// File: rtl/readout_pkg.sv
// Shared definitions for the line readout sequencer: FSM state encoding,
// default geometry constants and the pulse-counter width.
package readout_pkg;

  localparam int DEF_IMAGE_SIZE = 16;
  localparam int DEF_INPUT_BITS = 8;

  // Total number of bits serialized into the shift register per line.
  localparam int WIDTH = DEF_IMAGE_SIZE * DEF_INPUT_BITS;

  // Each pixel needs at most 3 pulses, so a 2-bit saturating counter is enough.
  localparam int PCNT_W = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_LOADP,
    S_MEASURE,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/pulse_completion_tracker.sv
// Per-pixel saturating pulse counters. all_done goes high once every pixel
// has shown PULSES_REQUIRED pulses since the last clear.
module pulse_completion_tracker #(
  parameter int IMAGE_SIZE      = readout_pkg::DEF_IMAGE_SIZE,
  parameter int PULSES_REQUIRED = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic [IMAGE_SIZE-1:0] i_pulse_in,
  output logic                  o_all_done
);
  import readout_pkg::*;

  localparam logic [PCNT_W-1:0] REQ = PCNT_W'(PULSES_REQUIRED);

  logic [PCNT_W-1:0] r_pulseCnt [IMAGE_SIZE];
  logic              w_allDone;

  // Count pulses per pixel, holding at the required count once reached.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        r_pulseCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < IMAGE_SIZE; i++) begin
        if (i_pulse_in[i] && (r_pulseCnt[i] != REQ)) begin
          r_pulseCnt[i] <= r_pulseCnt[i] + PCNT_W'(1);
        end
      end
    end
  end

  // AND-reduce the per-pixel "reached" conditions.
  always_comb begin
    w_allDone = 1'b1;
    for (int i = 0; i < IMAGE_SIZE; i++) begin
      w_allDone = w_allDone & (r_pulseCnt[i] == REQ);
    end
    o_all_done = w_allDone;
  end

endmodule

// File: rtl/line_readout_sequencer.sv
// Line readout sequencer: serializes one line of pixel bytes into the shift
// register, strobes LOAD, waits for every pixel's counter to settle (or a
// timeout), snapshots all PERIOD values and streams them out one per pixel.
// Optional build macro LINE_HEADER_EN prepends a header word
// {TIMEOUT_FLAG, line_count} to every drained line.
module line_readout_sequencer #(
  parameter int IMAGE_SIZE      = readout_pkg::DEF_IMAGE_SIZE,
  parameter int INPUT_BITS      = readout_pkg::DEF_INPUT_BITS,
  parameter int COUNTER_BITS    = 15,
  parameter int PULSES_REQUIRED = 2,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_start,
  input  logic [INPUT_BITS-1:0]              i_pix_data,
  input  logic                               i_pix_valid,
  output logic                               o_pix_ready,
  output logic                               o_shift_en,
  output logic                               o_shift_out,
  output logic                               o_load,
  input  logic [IMAGE_SIZE-1:0]              i_pulse_in,
  input  logic [IMAGE_SIZE*COUNTER_BITS-1:0] i_period_in,
  output logic [COUNTER_BITS-1:0]            o_out_data,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic                               o_out_last,
  output logic                               o_busy,
  output logic                               o_timeout_flag
);
  import readout_pkg::*;

  localparam int IDXW = $clog2(IMAGE_SIZE + 1);
  localparam int BITW = $clog2(INPUT_BITS + 1);
  localparam int TOW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(IMAGE_SIZE - 1);
  localparam logic [BITW-1:0] LAST_BIT = BITW'(INPUT_BITS - 1);
  localparam logic [TOW-1:0]  TO_LAST  = TOW'(TIMEOUT_CYCLES - 1);

  state_t r_state;
  state_t w_nextState;

  logic [IDXW-1:0]                    r_pixIdx;
  logic [BITW-1:0]                    r_bitCnt;
  logic [INPUT_BITS-1:0]              r_pixByte;
  logic [TOW-1:0]                     r_toCnt;
  logic [IMAGE_SIZE*COUNTER_BITS-1:0] r_snapshot;
  logic [IDXW-1:0]                    r_wordIdx;
  logic                               r_timeoutFlag;

  logic                    w_allDone;
  logic                    w_trackClear;
  logic [IMAGE_SIZE-1:0]   w_pulseGated;
  logic                    w_lastBit;
  logic                    w_capture;
  logic                    w_timeoutHit;
  logic                    w_outFire;
  logic                    w_headerPhase;
  logic                    w_lastWord;
  logic [COUNTER_BITS-1:0] w_pixelWord;

`ifdef LINE_HEADER_EN
  logic [COUNTER_BITS-2:0] r_lineCount;
  logic                    r_headerPending;
  assign w_headerPhase = r_headerPending;
`else
  assign w_headerPhase = 1'b0;
`endif

  // Pulses only count while measuring; LOADP restarts every pixel's count.
  assign w_pulseGated = (r_state == S_MEASURE) ? i_pulse_in : '0;
  assign w_trackClear = (r_state == S_LOADP);

  pulse_completion_tracker #(
    .IMAGE_SIZE      (IMAGE_SIZE),
    .PULSES_REQUIRED (PULSES_REQUIRED)
  ) u_tracker (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_trackClear),
    .i_pulse_in (w_pulseGated),
    .o_all_done (w_allDone)
  );

  // State register; reset abandons any partially processed line.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake/strobe outputs.
  always_comb begin
    w_nextState  = r_state;
    o_pix_ready  = 1'b0;
    o_shift_en   = 1'b0;
    o_load       = 1'b0;
    o_out_valid  = 1'b0;
    w_lastBit    = (r_bitCnt == LAST_BIT);
    w_capture    = 1'b0;
    w_timeoutHit = 1'b0;
    w_outFire    = 1'b0;
    w_lastWord   = (r_wordIdx == LAST_IDX) && !w_headerPhase;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nextState = S_FETCH;
        end
      end
      S_FETCH: begin
        o_pix_ready = 1'b1;
        if (i_pix_valid) begin
          w_nextState = S_SHIFT;
        end
      end
      S_SHIFT: begin
        o_shift_en = 1'b1;
        if (w_lastBit) begin
          w_nextState = (r_pixIdx == LAST_IDX) ? S_LOADP : S_FETCH;
        end
      end
      S_LOADP: begin
        o_load      = 1'b1;
        w_nextState = S_MEASURE;
      end
      S_MEASURE: begin
        if (w_allDone) begin
          w_capture   = 1'b1;
          w_nextState = S_DRAIN;
        end else if (r_toCnt == TO_LAST) begin
          w_capture    = 1'b1;
          w_timeoutHit = 1'b1;
          w_nextState  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_out_valid = 1'b1;
        w_outFire   = i_out_ready;
        if (i_out_ready && w_lastWord) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Datapath: pixel serializer, timeout counter, snapshot and drain index.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pixIdx      <= '0;
      r_bitCnt      <= '0;
      r_pixByte     <= '0;
      r_toCnt       <= '0;
      r_snapshot    <= '0;
      r_wordIdx     <= '0;
      r_timeoutFlag <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_timeoutFlag <= 1'b0;
            r_pixIdx      <= '0;
          end
        end
        S_FETCH: begin
          if (i_pix_valid) begin
            r_pixByte <= i_pix_data;
            r_bitCnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_pixByte <= r_pixByte << 1;
          r_bitCnt  <= r_bitCnt + BITW'(1);
          if (w_lastBit) begin
            r_pixIdx <= r_pixIdx + IDXW'(1);
          end
        end
        S_LOADP: begin
          r_toCnt   <= '0;
          r_wordIdx <= '0;
        end
        S_MEASURE: begin
          r_toCnt <= r_toCnt + TOW'(1);
          if (w_capture) begin
            r_snapshot <= i_period_in;
          end
          if (w_timeoutHit) begin
            r_timeoutFlag <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_outFire && !w_headerPhase) begin
            r_wordIdx <= r_wordIdx + IDXW'(1);
          end
        end
        default: begin
          r_toCnt <= '0;
        end
      endcase
    end
  end

`ifdef LINE_HEADER_EN
  // Header bookkeeping: one header per drained line, counter bumps per line.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lineCount     <= '0;
      r_headerPending <= 1'b0;
    end else begin
      if (r_state == S_LOADP) begin
        r_headerPending <= 1'b1;
      end else if ((r_state == S_DRAIN) && w_outFire && r_headerPending) begin
        r_headerPending <= 1'b0;
      end
      if ((r_state == S_DRAIN) && w_outFire && w_lastWord) begin
        r_lineCount <= r_lineCount + (COUNTER_BITS-1)'(1);
      end
    end
  end
`endif

  // Output word selection; every data-bearing output is zero outside its state.
  always_comb begin
    w_pixelWord    = r_snapshot[int'(r_wordIdx)*COUNTER_BITS +: COUNTER_BITS];
    o_shift_out    = (r_state == S_SHIFT) && r_pixByte[INPUT_BITS-1];
    o_busy         = (r_state != S_IDLE);
    o_timeout_flag = r_timeoutFlag;
    o_out_last     = (r_state == S_DRAIN) && w_lastWord;
    o_out_data     = '0;
    if (r_state == S_DRAIN) begin
`ifdef LINE_HEADER_EN
      o_out_data = r_headerPending ? {r_timeoutFlag, r_lineCount} : w_pixelWord;
`else
      o_out_data = w_pixelWord;
`endif
    end
  end

endmodule

// File: tb/tb_line_readout_sequencer.sv
// Scoreboard bench for line_readout_sequencer on a 4-pixel line with a
// 100-cycle timeout. Expected bits and words are queued when a line is
// issued; a negedge monitor pops and compares whatever the DUT presents.
module tb_line_readout_sequencer;

  localparam int N  = 4;
  localparam int B  = 8;
  localparam int CB = 15;
  localparam int PR = 2;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [B-1:0]  i_pix_data;
  logic          i_pix_valid;
  logic          o_pix_ready;
  logic          o_shift_en;
  logic          o_shift_out;
  logic          o_load;
  logic [N-1:0]  i_pulse_in;
  logic [N*CB-1:0] i_period_in;
  logic [CB-1:0] o_out_data;
  logic          o_out_valid;
  logic          i_out_ready;
  logic          o_out_last;
  logic          o_busy;
  logic          o_timeout_flag;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int linesDone = 0;

  logic [CB:0] outQ [$];
  logic        bitQ [$];
  logic        bitCheckEn = 1'b0;
  logic [31:0] expLoadWord = '0;
  int          shiftCount = 0;
  logic [31:0] shiftModel = '0;
  logic        stallMode = 1'b0;
  int          phase = 0;
  logic        readyPat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic        prevStall = 1'b0;
  logic [CB:0] prevWord = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  line_readout_sequencer #(
    .IMAGE_SIZE      (N),
    .INPUT_BITS      (B),
    .COUNTER_BITS    (CB),
    .PULSES_REQUIRED (PR),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (i_start),
    .i_pix_data     (i_pix_data),
    .i_pix_valid    (i_pix_valid),
    .o_pix_ready    (o_pix_ready),
    .o_shift_en     (o_shift_en),
    .o_shift_out    (o_shift_out),
    .o_load         (o_load),
    .i_pulse_in     (i_pulse_in),
    .i_period_in    (i_period_in),
    .o_out_data     (o_out_data),
    .o_out_valid    (o_out_valid),
    .i_out_ready    (i_out_ready),
    .o_out_last     (o_out_last),
    .o_busy         (o_busy),
    .o_timeout_flag (o_timeout_flag)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: event not observed within its cycle budget", name);
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_pix_ready"}, 32'(o_pix_ready), 0);
    checkOutput({tag, "_shift_en"}, 32'(o_shift_en), 0);
    checkOutput({tag, "_shift_out"}, 32'(o_shift_out), 0);
    checkOutput({tag, "_load"}, 32'(o_load), 0);
    checkOutput({tag, "_out_data"}, 32'(o_out_data), 0);
    checkOutput({tag, "_out_valid"}, 32'(o_out_valid), 0);
    checkOutput({tag, "_out_last"}, 32'(o_out_last), 0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 0);
    checkOutput({tag, "_timeout_flag"}, 32'(o_timeout_flag), 0);
  endtask

  // Consumer-side OUT_READY pattern: steady high, or 1,0,0,1 when stalling.
  always @(posedge clk) begin
    #1;
    if (stallMode) begin
      i_out_ready = readyPat[phase];
      phase = (phase + 1) % 4;
    end else begin
      i_out_ready = 1'b1;
      phase = 0;
    end
  end

  // Monitor: models the external shift register and checks serial bits,
  // the LOAD-time contents, and every accepted output word.
  always @(negedge clk) begin
    if (!rst_n) begin
      shiftCount = 0;
      shiftModel = '0;
      prevStall  = 1'b0;
    end else begin
      if (o_shift_en) begin
        shiftCount++;
        shiftModel = {shiftModel[30:0], o_shift_out};
        if (bitCheckEn) begin
          if (bitQ.size() == 0) reportFail("extra_shift_bit");
          else checkOutput("shift_bit", 32'(o_shift_out), 32'(bitQ.pop_front()));
        end
      end
      if (o_load) begin
        if (bitCheckEn) begin
          checkOutput("shift_count", shiftCount, N * B);
          checkOutput("loaded_word", shiftModel, expLoadWord);
        end
        shiftCount = 0;
      end
      if (o_out_valid) begin
        if (prevStall) checkOutput("stall_hold", 32'({o_out_last, o_out_data}), 32'(prevWord));
        if (i_out_ready) begin
          if (outQ.size() == 0) reportFail("unexpected_word");
          else checkOutput("out_word", 32'({o_out_last, o_out_data}), 32'(outQ.pop_front()));
        end
        prevStall = !i_out_ready;
        prevWord  = {o_out_last, o_out_data};
      end else begin
        prevStall = 1'b0;
      end
    end
  end

  task automatic waitReady(input string name);
    bit seen = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (o_pix_ready) begin
        seen = 1;
        break;
      end
    end
    if (!seen) reportFail(name);
  endtask

  // Issue one full line and queue everything the DUT should produce for it.
  // pixWord holds the first pixel in its top byte.
  task automatic applyStimulus(input logic [31:0] pixWord, input int gap,
                               input logic [N-1:0] pulseMask, input logic [N*CB-1:0] period,
                               input logic stall, input logic expTimeout);
    int  loadCycle = 0;
    int  drainCycle = 0;
    bit  seen;
    bitQ.delete();
    for (int i = 31; i >= 0; i--) bitQ.push_back(pixWord[i]);
    expLoadWord = pixWord;
    bitCheckEn  = 1'b1;
`ifdef LINE_HEADER_EN
    outQ.push_back({1'b0, expTimeout, linesDone[CB-2:0]});
`endif
    for (int k = 0; k < N; k++) outQ.push_back({(k == N - 1), period[k*CB +: CB]});
    i_period_in = period;
    stallMode   = stall;

    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    for (int p = 0; p < N; p++) begin
      if (p > 0 && gap > 0) begin
        waitReady("gap_fetch");
        for (int g = 0; g < gap; g++) begin
          checkOutput("gap_shift_en", 32'(o_shift_en), 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
      end
      i_pix_data  = pixWord[31 - 8*p -: 8];
      i_pix_valid = 1'b1;
      waitReady("pix_handshake");
      @(posedge clk); #1 i_pix_valid = 1'b0;
    end

    seen = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (o_load) begin
        seen = 1;
        break;
      end
    end
    if (!seen) reportFail("load_strobe");
    loadCycle = cycle;

    // Each enabled pixel pulses twice, staggered by pixel index.
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) i_pulse_in[i] = pulseMask[i] && (c == 2 + i || c == 6 + i);
      @(negedge clk);
      if (o_out_valid) begin
        seen = 1;
        drainCycle = cycle;
        break;
      end
    end
    i_pulse_in = '0;
    if (!seen) begin
      reportFail("drain_start");
    end else begin
      checkOutput("timeout_flag", 32'(o_timeout_flag), 32'(expTimeout));
      // LOAD cycle plus TO cycles of MEASURE before DRAIN appears.
      if (expTimeout) checkOutput("timeout_latency", drainCycle - loadCycle, TO + 1);
      i_period_in = '1;
    end

    for (int t = 0; t < 100; t++) begin
      if (outQ.size() == 0) break;
      @(negedge clk);
    end
    if (outQ.size() != 0) reportFail("drain_complete");
    @(negedge clk);
    checkOutput("valid_drop", 32'(o_out_valid), 0);
    checkOutput("busy_drop", 32'(o_busy), 0);
    stallMode  = 1'b0;
    bitCheckEn = 1'b0;
    outQ.delete();
    linesDone++;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    i_start     = 1'b0;
    i_pix_data  = '0;
    i_pix_valid = 1'b0;
    i_pulse_in  = '0;
    i_period_in = '0;
    i_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleZero("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] line 1: back-to-back pixels, all pixels complete");
    applyStimulus(32'hA53CFF00, 0, 4'b1111, {15'd40, 15'd30, 15'd20, 15'd10}, 1'b0, 1'b0);

    $display("[TB] line 2: 5-cycle gaps between pixel bytes");
    applyStimulus(32'hA53CFF00, 5, 4'b1111, {15'd40, 15'd30, 15'd20, 15'd10}, 1'b0, 1'b0);

    $display("[TB] line 3: pixel 2 never pulses, timeout expected");
    applyStimulus(32'h5A0181FE, 0, 4'b1011, {15'd4444, 15'd3333, 15'd2222, 15'd1111}, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("timeout_sticky", 32'(o_timeout_flag), 1);

    $display("[TB] line 4: OUT_READY stalls 1,0,0,1");
    applyStimulus(32'h13579BDF, 0, 4'b1111, {15'd400, 15'd300, 15'd200, 15'd100}, 1'b1, 1'b0);

    $display("[TB] abort: reset in the middle of SHIFT");
    @(posedge clk); #1 i_start = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    i_pix_data  = 8'h12;
    i_pix_valid = 1'b1;
    waitReady("abort_handshake");
    @(posedge clk); #1 i_pix_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkIdleZero("abort");
    linesDone = 0;

    $display("[TB] line 5: fresh line after abort");
    applyStimulus(32'h0180AA55, 0, 4'b1111, {15'd32767, 15'd1, 15'd16384, 15'd7}, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
